// File: rtl/prbs_stream_gen_if.sv
// AXI4-Stream style master channel carried by prbs_stream_gen: data, valid, last
// out of the generator and ready back from the consumer.
interface prbs_stream_gen_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/prbs_stream_gen.sv
// PRBS word stream generator (right-shift Galois LFSR) with counted/continuous
// streams and early stop. Optional bit-0 error injection: PRBS_STREAM_GEN_ERR_INJECT_EN.
module prbs_stream_gen #(
  parameter logic [31:0] SEED = 32'h0000_0001,
  parameter logic [31:0] POLY = 32'hA300_0000
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                start,
  input  logic                stop,
  input  logic [31:0]         num_words,
  prbs_stream_gen_if.master   m_axis,
  output logic                busy,
  output logic [31:0]         sent_count
`ifdef PRBS_STREAM_GEN_ERR_INJECT_EN
  ,
  input  logic                inject_err,
  output logic [31:0]         inj_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        busy_q, busy_d;
  logic [31:0] sent_count_q, sent_count_d;
  logic [31:0] num_words_q, num_words_d;

`ifdef PRBS_STREAM_GEN_ERR_INJECT_EN
  logic        pending_q, pending_d;
  logic        word_inj_q, word_inj_d;
  logic [31:0] inj_count_q, inj_count_d;
`endif

  logic        hs;
  logic        inj_pend;
  logic        load;
  logic [31:0] load_val;
  logic        go_idle;
  logic [31:0] lfsr_next;

  assign hs        = tvalid_q & m_axis.tready;
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : '0);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    busy_d       = busy_q;
    sent_count_d = sent_count_q;
    num_words_d  = num_words_q;
    load         = 1'b0;
    load_val     = lfsr_q;
    go_idle      = 1'b0;

`ifdef PRBS_STREAM_GEN_ERR_INJECT_EN
    inj_pend     = pending_q | inject_err;
`else
    inj_pend     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous stop; stop alone does nothing here
        if (start) begin
          state_d      = RUN;
          lfsr_d       = SEED;
          sent_count_d = '0;
          num_words_d  = num_words;
          tvalid_d     = 1'b1;
          busy_d       = 1'b1;
          tlast_d      = (num_words == 32'd1);
          load         = 1'b1;
          load_val     = SEED;
        end
      end

      RUN: begin
        if (hs) begin
          sent_count_d = sent_count_q + 32'd1;
          lfsr_d       = lfsr_next;
          if (tlast_q || stop) begin
            go_idle = 1'b1;
          end else begin
            // tlast for the following word: its index will be sent_count_q+1
            tlast_d  = (num_words_q != '0) &&
                       (sent_count_q + 32'd1 == num_words_q - 32'd1);
            load     = 1'b1;
            load_val = lfsr_next;
          end
        end else if (stop) begin
          state_d = STOPPING;
        end
      end

      STOPPING: begin
        if (hs) begin
          sent_count_d = sent_count_q + 32'd1;
          lfsr_d       = lfsr_next;
          go_idle      = 1'b1;
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (load) begin
      tdata_d = load_val ^ {31'b0, inj_pend};
    end

    if (go_idle) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      busy_d   = 1'b0;
    end
  end

`ifdef PRBS_STREAM_GEN_ERR_INJECT_EN
  always_comb begin
    pending_d   = inj_pend;
    word_inj_d  = word_inj_q;
    inj_count_d = inj_count_q;
    if (hs && word_inj_q) begin
      inj_count_d = inj_count_q + 32'd1;
    end
    if (load) begin
      word_inj_d = inj_pend;
      pending_d  = 1'b0;
    end else if (hs) begin
      word_inj_d = 1'b0;
    end
    if (go_idle) begin
      pending_d  = 1'b0;
      word_inj_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pending_q   <= 1'b0;
      word_inj_q  <= 1'b0;
      inj_count_q <= '0;
    end else begin
      pending_q   <= pending_d;
      word_inj_q  <= word_inj_d;
      inj_count_q <= inj_count_d;
    end
  end

  assign inj_count = inj_count_q;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      sent_count_q <= '0;
      num_words_q  <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      sent_count_q <= sent_count_d;
      num_words_q  <= num_words_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign sent_count    = sent_count_q;

endmodule

// File: doc/prbs_stream_gen.md
PRBS_STREAM_GEN -- requirements
Module: prbs_stream_gen

Interface
REQ-001 The block SHALL have parameter SEED, default 32'h0000_0001, LFSR load value on reset and on each start; MUST be nonzero.
REQ-002 The block SHALL have parameter POLY, default 32'hA300_0000, right-shift Galois LFSR feedback mask.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse, begins a stream when IDLE.
REQ-006 stop  input  1  single-cycle pulse, ends a continuous or counted stream early.
REQ-007 num_words  input  32  stream length, sampled on accepted start; 0 = continuous.
REQ-008 M_AXIS_TDATA  output  32  PRBS word.
REQ-009 M_AXIS_TVALID  output  1  word valid.
REQ-010 M_AXIS_TREADY  input  1  downstream ready.
REQ-011 M_AXIS_TLAST  output  1  high on final word of a counted stream only.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 sent_count  output  32  handshakes completed since last accepted start.

Function
REQ-014 The block SHALL implement states IDLE, RUN, STOPPING.
REQ-015 IDLE: TVALID=0; start SHALL load LFSR=SEED, clear sent_count, latch num_words, go to RUN; stop in IDLE SHALL be ignored; start and stop together in IDLE SHALL act as start only.
REQ-016 RUN: TVALID=1, TDATA=LFSR state; first word SHALL appear the cycle after start (latency 1).
REQ-017 Handshake = TVALID & TREADY; on handshake LFSR SHALL advance once: next = (s>>1) ^ (s[0] ? POLY : 0); sent_count SHALL increment.
REQ-018 TDATA, TLAST SHALL be stable while TVALID=1 and TREADY=0; TVALID SHALL not drop without a handshake except on reset.
REQ-019 TLAST SHALL be 1 when num_words!=0 and sent_count==num_words-1; handshake of that word SHALL go to IDLE.
REQ-020 stop in RUN with handshake same cycle SHALL go to IDLE; stop without handshake SHALL go to STOPPING.
REQ-021 STOPPING: current word held (TVALID=1, TDATA/TLAST unchanged) until handshake, then IDLE.
REQ-022 start outside IDLE SHALL be ignored; stop in STOPPING SHALL be ignored.
REQ-023 sent_count SHALL wrap 32'hFFFF_FFFF -> 0 in continuous mode without affecting state; num_words=1 SHALL give one word with TLAST=1.

Reset
REQ-024 aresetn low SHALL immediately force: state IDLE, TVALID=0, TLAST=0, TDATA=0, busy=0, sent_count=0, LFSR=SEED, injection state cleared (inj_count=0).
REQ-025 Reset mid-stream SHALL abort the word in flight; next start SHALL restart the sequence from SEED.

Configuration
REQ-026 With PRBS_STREAM_GEN_ERR_INJECT_EN defined: ports inject_err (input 1) and inj_count (output 32) SHALL exist; inject_err pulse sets a pending flag; the next word loaded onto TDATA (at start or after a handshake) SHALL have bit 0 inverted, flag cleared, inj_count incremented on that word's handshake; LFSR sequence SHALL be unaffected; pending flag SHALL be cleared on entry to IDLE.
REQ-027 Without PRBS_STREAM_GEN_ERR_INJECT_EN: ports absent, TDATA SHALL always equal LFSR state.

Verification
REQ-028 num_words=4, TREADY=1, start -> TDATA 0x00000001, 0xA3000000, 0x51800000, 0x28C00000 on consecutive cycles, TLAST only on 4th, busy low next cycle, sent_count=4.
REQ-029 num_words=4, TREADY low 3 cycles while word 2 presented -> TDATA=0xA3000000, TVALID=1, TLAST=0 stable throughout; same 4 words, none skipped or repeated.
REQ-030 num_words=0, TREADY=0 while 11th word presented, stop pulse -> STOPPING, word held; TREADY=1 -> handshake, IDLE, sent_count=11, TVALID=0 next cycle.
REQ-031 ERR_INJECT_EN, num_words=4, inject_err pulse during word 2 handshake -> words 0x00000001, 0xA3000000, 0x51800001, 0x28C00000; inj_count=1.
REQ-032 aresetn low 2 cycles during word 3, then start -> TVALID 0 during reset, sequence restarts at 0x00000001, sent_count restarts at 0.
REQ-033 num_words=1, start; start re-pulsed while busy -> single word 0x00000001 with TLAST=1, second start ignored, sent_count=1.
